univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 107 ++++++++++
 tb/tb_univ_shift_reg.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register stepped by a synchronised (optionally debounced) push-button.
// Define UNIV_SHIFT_REG_DEBOUNCE_EN to build the debounce counter in front of the edge detector.
module univ_shift_reg #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_btn,
    input  logic [2:0]       mode,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic             step_pulse,
    output logic [7:0]       step_count
);

    if (WIDTH < 2 || WIDTH > 64 || DEBOUNCE_CYCLES < 2) begin : g_bad_param
        $error("univ_shift_reg: WIDTH must be 2..64 and DEBOUNCE_CYCLES >= 2");
    end

    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_ROR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_LOAD  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    logic btn_meta;
    logic btn_sync;
    logic btn_qual;
    logic qual_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= step_btn;
            btn_sync <= btn_meta;
        end
    end

`ifdef UNIV_SHIFT_REG_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt;
    logic             db_level;

    // Any cycle agreeing with the qualified level restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (btn_sync == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_LAST) begin
            db_cnt   <= '0;
            db_level <= btn_sync;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign btn_qual = db_level;
`else
    assign btn_qual = btn_sync;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qual_d <= 1'b0;
        end else begin
            qual_d <= btn_qual;
        end
    end

    assign step_pulse = btn_qual & ~qual_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q          <= '0;
            step_count <= '0;
        end else if (step_pulse) begin
            case (mode)
                MODE_SHR:   q <= {ser_in_r, q[WIDTH-1:1]};
                MODE_SHL:   q <= {q[WIDTH-2:0], ser_in_l};
                MODE_ROR:   q <= {q[0], q[WIDTH-1:1]};
                MODE_ROL:   q <= {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_LOAD:  q <= load_data;
                MODE_CLEAR: q <= '0;
                default:    q <= q;
            endcase
            if (mode != 3'b000 && mode != 3'b111) begin
                step_count <= step_count + 8'd1;
            end
        end
    end

    assign ser_out_r = q[0];
    assign ser_out_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8, DEBOUNCE_CYCLES=4): directed and random presses
// checked against an arithmetic model of the register and step counter.
module tb_univ_shift_reg;
    localparam int W = 8;
    localparam int D = 4;
`ifdef UNIV_SHIFT_REG_DEBOUNCE_EN
    localparam int LAT    = D + 2;
    localparam int SETTLE = D + 6;
`else
    localparam int LAT    = 2;
    localparam int SETTLE = 6;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         step_btn;
    logic [2:0]   mode;
    logic         ser_in_r;
    logic         ser_in_l;
    logic [W-1:0] load_data;
    logic [W-1:0] q;
    logic         ser_out_r;
    logic         ser_out_l;
    logic         step_pulse;
    logic [7:0]   step_count;

    int checks = 0;
    int failures = 0;
    int pulse_total = 0;
    logic [W-1:0] m_q;
    int m_cnt;

    univ_shift_reg #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .step_btn(step_btn), .mode(mode),
        .ser_in_r(ser_in_r), .ser_in_l(ser_in_l), .load_data(load_data),
        .q(q), .ser_out_r(ser_out_r), .ser_out_l(ser_out_l),
        .step_pulse(step_pulse), .step_count(step_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (step_pulse === 1'b1) pulse_total++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: register as an unsigned number, ops as arithmetic.
    task automatic model_step(input logic [2:0] md);
        int v;
        v = int'(m_q);
        case (md)
            3'd1: v = v / 2 + (ser_in_r ? 2 ** (W - 1) : 0);
            3'd2: v = (v * 2) % (2 ** W) + (ser_in_l ? 1 : 0);
            3'd3: v = v / 2 + (v % 2) * 2 ** (W - 1);
            3'd4: v = (v * 2) % (2 ** W) + v / 2 ** (W - 1);
            3'd5: v = int'(load_data);
            3'd6: v = 0;
            default: ;
        endcase
        m_q = W'(v);
        if (md >= 3'd1 && md <= 3'd6) m_cnt = (m_cnt + 1) % 256;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_q"}, q, m_q);
        check({tag, "_cnt"}, step_count, m_cnt);
        check({tag, "_sor"}, ser_out_r, m_q[0]);
        check({tag, "_sol"}, ser_out_l, m_q[W-1]);
    endtask

    task automatic press(input string tag, input int hold);
        int n;
        int p0;
        @(negedge clk);
        p0 = pulse_total;
        step_btn = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (step_pulse !== 1'b1 && n < LAT + 20);
        check({tag, "_lat"}, n, LAT);
        check({tag, "_pre"}, q, m_q);
        model_step(mode);
        @(negedge clk);
        check_state(tag);
        repeat (hold) @(negedge clk);
        step_btn = 1'b0;
        repeat (SETTLE) @(negedge clk);
        check({tag, "_npulse"}, pulse_total - p0, 1);
    endtask

    initial begin
        int p0;
        int n;
        rst = 1'b1; step_btn = 1'b0; mode = 3'd0;
        ser_in_r = 1'b0; ser_in_l = 1'b0; load_data = '0;
        m_q = '0; m_cnt = 0;
        repeat (3) @(negedge clk);
        check("rst_q", q, 0);
        check("rst_cnt", step_count, 0);
        check("rst_pulse", step_pulse, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        mode = 3'd5; load_data = 8'hA5;
        press("load_a5", 2);
        check("load_a5_const", q, 8'hA5);
        check("load_a5_cnt1", step_count, 1);

        mode = 3'd1; ser_in_r = 1'b1;
        press("shr", 1);
        check("shr_const", q, 8'hD2);
        mode = 3'd3;
        press("ror", 3);
        check("ror_const", q, 8'h69);
        mode = 3'd4;
        press("rol", 0);
        check("rol_const", q, 8'hD2);

        mode = 3'd5; load_data = 8'h81;
        press("load_81", 1);
        mode = 3'd2; ser_in_l = 1'b0;
        press("shl", 2);
        check("shl_const", q, 8'h02);
        mode = 3'd0;
        press("hold0", 1);
        check("hold0_const", q, 8'h02);
        mode = 3'd7;
        press("hold7", 1);

        for (int i = 0; i < 30; i++) begin
            mode      = 3'($urandom_range(0, 7));
            ser_in_r  = 1'($urandom_range(0, 1));
            ser_in_l  = 1'($urandom_range(0, 1));
            load_data = W'($urandom);
            press($sformatf("rnd%0d", i), int'($urandom_range(0, 5)));
        end

`ifdef UNIV_SHIFT_REG_DEBOUNCE_EN
        @(negedge clk);
        p0 = pulse_total;
        mode = 3'd5; load_data = 8'h3C;
        step_btn = 1'b1;
        repeat (D - 1) @(negedge clk);
        step_btn = 1'b0;
        repeat (SETTLE) @(negedge clk);
        check("glitch_npulse", pulse_total - p0, 0);
        check_state("glitch");
        press("long_hold", 100);
`endif

        mode = 3'd6;
        while (m_cnt != 255) press("clr_fill", 0);
        press("clr_wrap", 0);
        check("wrap_cnt_const", step_count, 0);
        check("wrap_q_const", q, 0);

        mode = 3'd5; load_data = 8'h5A;
        press("pre_rst", 0);
        load_data = 8'hC3;
        @(negedge clk);
        step_btn = 1'b1;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        m_q = '0; m_cnt = 0;
        check("midrst_q", q, 0);
        check("midrst_cnt", step_count, 0);
        check("midrst_pulse", step_pulse, 0);
        check("midrst_sol", ser_out_l, 0);
        @(negedge clk);
        rst = 1'b0;
        p0 = pulse_total;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (step_pulse !== 1'b1 && n < LAT + 20);
        check("postrst_lat", n, LAT);
        model_step(mode);
        @(negedge clk);
        check_state("postrst");
        check("postrst_const", q, 8'hC3);
        repeat (20) @(negedge clk);
        check("postrst_npulse", pulse_total - p0, 1);
        step_btn = 1'b0;
        repeat (SETTLE) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
